serial_frame_receiver: RTL and testbench

Parametrised asynchronous serial frame receiver: generalises the fixed 10-bit serial-to-parallel receiver with configurable data width, oversampling ratio, optional parity and 1/2 stop bits. It synchronises the line, detects start bits, samples each bit at its midpoint, checks framing and parity, and delivers words through a valid/ready holding register. It sits between an external serial pin and any parallel consumer in the design.

---
 rtl/serial_frame_receiver.sv | 161 ++++++++++++++++
 tb/tb_serial_frame_receiver.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - parametrised async serial frame receiver with valid/ready holding register
module serial_frame_receiver #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 SerialIN,
    output logic [DATA_BITS-1:0] ParallelOUT,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic                 FrameErr,
    output logic                 ParityErr,
    output logic                 Overrun,
    output logic                 Busy
);
    localparam int HALF   = CLKS_PER_BIT / 2;
    localparam int TICK_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = 5;
    localparam logic [TICK_W-1:0] HALF_TICK  = TICK_W'(HALF - 1);
    localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_DATA  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP  = BIT_W'(STOP_BITS - 1);
    localparam logic              ODD_PARITY = (PARITY_MODE == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rxState_t;

    rxState_t             state;
    logic                 syncA, syncB, prevLine;
    logic [1:0]           settleCnt;
    logic                 armed;
    logic [TICK_W-1:0]    tickCnt;
    logic [BIT_W-1:0]     bitCnt;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 parityErrAcc;
    logic                 stopErrAcc;

    logic startEdge, tickDone, frameErrNext;

    assign startEdge    = armed && prevLine && !syncB;
    assign tickDone     = (tickCnt == LAST_TICK);
    assign frameErrNext = stopErrAcc | ~syncB;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= IDLE;
            syncA        <= 1'b1;
            syncB        <= 1'b1;
            prevLine     <= 1'b1;
            settleCnt    <= 2'd0;
            armed        <= 1'b0;
            tickCnt      <= '0;
            bitCnt       <= '0;
            shiftReg     <= '0;
            parityErrAcc <= 1'b0;
            stopErrAcc   <= 1'b0;
            ParallelOUT  <= '0;
            OutValid     <= 1'b0;
            FrameErr     <= 1'b0;
            ParityErr    <= 1'b0;
            Overrun      <= 1'b0;
            Busy         <= 1'b0;
        end else begin
            syncA    <= SerialIN;
            syncB    <= syncA;
            prevLine <= syncB;

            // The synchroniser resets to 1, so a line held low across reset must be
            // seen high at least once before a falling edge counts as a start.
            if (settleCnt != 2'd2) begin
                settleCnt <= settleCnt + 2'd1;
            end else if (syncB) begin
                armed <= 1'b1;
            end

            Overrun <= 1'b0;
            if (OutValid && OutReady) begin
                OutValid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (startEdge) begin
                        state   <= START;
                        tickCnt <= '0;
                        Busy    <= 1'b1;
                    end
                end
                START: begin
                    if (tickCnt == HALF_TICK) begin
                        tickCnt      <= '0;
                        bitCnt       <= '0;
                        parityErrAcc <= 1'b0;
                        stopErrAcc   <= 1'b0;
                        if (syncB) begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        tickCnt <= tickCnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tickDone) begin
                        tickCnt  <= '0;
                        shiftReg <= {syncB, shiftReg[DATA_BITS-1:1]};
                        if (bitCnt == LAST_DATA) begin
                            bitCnt <= '0;
                            state  <= (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            bitCnt <= bitCnt + 1'b1;
                        end
                    end else begin
                        tickCnt <= tickCnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (tickDone) begin
                        tickCnt      <= '0;
                        parityErrAcc <= ((^shiftReg) ^ syncB) != ODD_PARITY;
                        state        <= STOP;
                    end else begin
                        tickCnt <= tickCnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tickDone) begin
                        tickCnt <= '0;
                        if (bitCnt == LAST_STOP) begin
                            bitCnt <= '0;
                            state  <= IDLE;
                            Busy   <= 1'b0;
                            // Load when the register is empty or being drained this cycle.
                            if (!OutValid || OutReady) begin
                                ParallelOUT <= shiftReg;
                                FrameErr    <= frameErrNext;
                                ParityErr   <= parityErrAcc;
                                OutValid    <= 1'b1;
                            end else begin
                                Overrun <= 1'b1;
                            end
                        end else begin
                            bitCnt     <= bitCnt + 1'b1;
                            stopErrAcc <= frameErrNext;
                        end
                    end else begin
                        tickCnt <= tickCnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - randomized and directed bench for serial_frame_receiver
module tb_serial_frame_receiver;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rstN;
    logic [2:0] lineIn, readyIn;
    logic [7:0] pOutA, pOutB;
    logic [5:0] pOutC;
    logic [2:0] valid, frameErr, parityErr, overrun, busy;

    // Instance 0: 8N1/16x, instance 1: 8E1/16x, instance 2: 6 bits odd parity 2 stop, 7x.
    int cfgBits[3] = '{8, 8, 6};
    int cfgCpb[3]  = '{16, 16, 7};
    int cfgPar[3]  = '{0, 1, 2};
    int cfgStop[3] = '{1, 1, 2};

    serial_frame_receiver uA (
        .CLK(CLK), .RST_N(rstN), .SerialIN(lineIn[0]), .ParallelOUT(pOutA),
        .OutValid(valid[0]), .OutReady(readyIn[0]), .FrameErr(frameErr[0]),
        .ParityErr(parityErr[0]), .Overrun(overrun[0]), .Busy(busy[0])
    );
    serial_frame_receiver #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY_MODE(1), .STOP_BITS(1)) uB (
        .CLK(CLK), .RST_N(rstN), .SerialIN(lineIn[1]), .ParallelOUT(pOutB),
        .OutValid(valid[1]), .OutReady(readyIn[1]), .FrameErr(frameErr[1]),
        .ParityErr(parityErr[1]), .Overrun(overrun[1]), .Busy(busy[1])
    );
    serial_frame_receiver #(.DATA_BITS(6), .CLKS_PER_BIT(7), .PARITY_MODE(2), .STOP_BITS(2)) uC (
        .CLK(CLK), .RST_N(rstN), .SerialIN(lineIn[2]), .ParallelOUT(pOutC),
        .OutValid(valid[2]), .OutReady(readyIn[2]), .FrameErr(frameErr[2]),
        .ParityErr(parityErr[2]), .Overrun(overrun[2]), .Busy(busy[2])
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        int          cyc;
        logic [15:0] data;
        logic        fe;
        logic        pe;
    } accEv_t;

    accEv_t accQ[$];
    int     ovIdx[$];
    int     ovCyc[$];
    int     busyRise[3];
    int     busyFall[3];
    logic [2:0] busyPrev = 3'b000;

    function automatic logic [15:0] outOf(int k);
        case (k)
            0:       return {8'h00, pOutA};
            1:       return {8'h00, pOutB};
            default: return {10'h000, pOutC};
        endcase
    endfunction

    always @(negedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            if (valid[k] && readyIn[k])
                accQ.push_back(accEv_t'{k, cyc, outOf(k), frameErr[k], parityErr[k]});
            if (overrun[k]) begin
                ovIdx.push_back(k);
                ovCyc.push_back(cyc);
            end
            if (busy[k] && !busyPrev[k]) busyRise[k] <= cyc;
            if (!busy[k] && busyPrev[k]) busyFall[k] <= cyc;
        end
        busyPrev <= busy;
    end

    int numChecks = 0;
    int numFails  = 0;

    task automatic checkVal(string tag, logic [31:0] got, logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int finalOf(int k, int dropCyc);
        int np = (cfgPar[k] != 0) ? 1 : 0;
        return dropCyc + 2 + cfgCpb[k] / 2 + (cfgBits[k] + np + cfgStop[k]) * cfgCpb[k];
    endfunction

    task automatic sendFrame(int k, logic [15:0] data, logic parBit, logic [1:0] stopVals,
                             output int dropCyc);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < cfgBits[k]; i++) bits.push_back(data[i]);
        if (cfgPar[k] != 0) bits.push_back(parBit);
        for (int s = 0; s < cfgStop[k]; s++) bits.push_back(stopVals[s]);
        @(posedge CLK); #1;
        dropCyc = cyc;
        foreach (bits[b]) begin
            lineIn[k] = bits[b];
            repeat (cfgCpb[k]) @(posedge CLK);
            #1;
        end
        lineIn[k] = 1'b1;
    endtask

    task automatic expectFrame(int k, logic [15:0] data, logic parBit, logic [1:0] stopVals,
                               int dropCyc, string tag);
        int          fin = finalOf(k, dropCyc);
        logic [15:0] expData = data & 16'((1 << cfgBits[k]) - 1);
        int          ones = $countones(expData);
        logic        expPe = (cfgPar[k] == 0) ? 1'b0
                           : ((((ones + int'(parBit)) % 2) == 1) != (cfgPar[k] == 2));
        logic        expFe = 1'b0;
        accEv_t      ev;
        for (int s = 0; s < cfgStop[k]; s++) if (!stopVals[s]) expFe = 1'b1;
        for (int t = 0; t < 400 && accQ.size() == 0; t++) @(posedge CLK);
        checkVal({tag, ".delivered"}, 32'(accQ.size() != 0), 32'd1);
        if (accQ.size() == 0) return;
        ev = accQ.pop_front();
        checkVal({tag, ".idx"}, ev.idx, k);
        checkVal({tag, ".cycle"}, ev.cyc, fin + 1);
        checkVal({tag, ".data"}, ev.data, expData);
        checkVal({tag, ".frameErr"}, ev.fe, expFe);
        checkVal({tag, ".parityErr"}, ev.pe, expPe);
        checkVal({tag, ".busyRise"}, busyRise[k], dropCyc + 3);
        checkVal({tag, ".busyFall"}, busyFall[k], fin + 1);
        repeat (3) @(posedge CLK);
        checkVal({tag, ".single"}, accQ.size(), 0);
        checkVal({tag, ".noOverrun"}, ovIdx.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1);
    end

    initial begin
        int          d, d2, d3, fin;
        logic [15:0] rdata;
        logic        rpar;
        logic [1:0]  rstop;
        accEv_t      ev;

        rstN    = 1'b0;
        lineIn  = 3'b111;
        readyIn = 3'b111;
        repeat (3) @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            checkVal($sformatf("reset%0d.valid", k), valid[k], 1'b0);
            checkVal($sformatf("reset%0d.busy", k), busy[k], 1'b0);
            checkVal($sformatf("reset%0d.flags", k), {frameErr[k], parityErr[k], overrun[k]}, 3'b000);
            checkVal($sformatf("reset%0d.data", k), outOf(k), 16'h0);
        end
        rstN = 1'b1;
        repeat (5) @(posedge CLK);

        sendFrame(0, 16'hA5, 1'b0, 2'b11, d);
        expectFrame(0, 16'hA5, 1'b0, 2'b11, d, "a5_8n1");

        sendFrame(1, 16'h03, 1'b1, 2'b11, d);
        expectFrame(1, 16'h03, 1'b1, 2'b11, d, "even_p1");
        sendFrame(1, 16'h03, 1'b0, 2'b11, d);
        expectFrame(1, 16'h03, 1'b0, 2'b11, d, "even_p0");
        sendFrame(2, 16'h03, 1'b1, 2'b11, d);
        expectFrame(2, 16'h03, 1'b1, 2'b11, d, "odd_p1");
        sendFrame(2, 16'h2A, 1'b0, 2'b01, d);
        expectFrame(2, 16'h2A, 1'b0, 2'b01, d, "stop2_low");

        sendFrame(0, 16'h55, 1'b0, 2'b10, d);
        expectFrame(0, 16'h55, 1'b0, 2'b10, d, "stop_low");

        // Holding register full: second frame is dropped, third completes on the accept cycle.
        readyIn[0] = 1'b0;
        sendFrame(0, 16'h11, 1'b0, 2'b11, d);
        repeat (10) @(posedge CLK);
        #1;
        checkVal("hold.valid", valid[0], 1'b1);
        checkVal("hold.data", pOutA, 8'h11);
        sendFrame(0, 16'h22, 1'b0, 2'b11, d2);
        for (int t = 0; t < 100 && ovIdx.size() == 0; t++) @(posedge CLK);
        checkVal("ovr.seen", 32'(ovIdx.size() != 0), 32'd1);
        if (ovIdx.size() != 0) begin
            checkVal("ovr.idx", ovIdx.pop_front(), 0);
            checkVal("ovr.cycle", ovCyc.pop_front(), finalOf(0, d2) + 1);
        end
        #1;
        checkVal("ovr.dataKept", pOutA, 8'h11);
        checkVal("ovr.pulseLen", overrun[0], 1'b0);
        fork
            sendFrame(0, 16'h33, 1'b0, 2'b11, d3);
            begin
                @(posedge CLK); #1;
                fin = finalOf(0, cyc);
                while (cyc < fin) begin
                    @(posedge CLK); #1;
                end
                readyIn[0] = 1'b1;
            end
        join
        repeat (10) @(posedge CLK);
        checkVal("swap.count", accQ.size(), 2);
        if (accQ.size() == 2) begin
            ev = accQ.pop_front();
            checkVal("swap.oldData", ev.data, 16'h11);
            checkVal("swap.oldCycle", ev.cyc, finalOf(0, d3));
            ev = accQ.pop_front();
            checkVal("swap.newData", ev.data, 16'h33);
            checkVal("swap.newCycle", ev.cyc, finalOf(0, d3) + 1);
        end
        accQ.delete();
        checkVal("swap.noOverrun", ovIdx.size(), 0);

        // Short low pulse is rejected at the start-bit midpoint.
        @(posedge CLK); #1;
        d = cyc;
        lineIn[0] = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        lineIn[0] = 1'b1;
        repeat (30) @(posedge CLK);
        #1;
        checkVal("glitch.noDelivery", accQ.size(), 0);
        checkVal("glitch.valid", valid[0], 1'b0);
        checkVal("glitch.busy", busy[0], 1'b0);
        checkVal("glitch.busyRise", busyRise[0], d + 3);
        checkVal("glitch.busyFall", busyFall[0], d + 11);
        checkVal("glitch.noOverrun", ovIdx.size(), 0);

        // Reset in the middle of data bit 4 with a word held.
        readyIn[0] = 1'b0;
        sendFrame(0, 16'h5A, 1'b0, 2'b11, d);
        repeat (5) @(posedge CLK);
        #1;
        checkVal("preRst.data", pOutA, 8'h5A);
        rdata = 16'h3C;
        @(posedge CLK); #1;
        lineIn[0] = 1'b0;
        repeat (16) @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            lineIn[0] = rdata[i];
            repeat (16) @(posedge CLK);
            #1;
        end
        lineIn[0] = rdata[4];
        repeat (8) @(posedge CLK);
        #1;
        checkVal("preRst.busy", busy[0], 1'b1);
        rstN = 1'b0;
        lineIn[0] = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checkVal("midRst.valid", valid[0], 1'b0);
        checkVal("midRst.data", pOutA, 8'h00);
        checkVal("midRst.flags", {frameErr[0], parityErr[0], overrun[0]}, 3'b000);
        checkVal("midRst.busy", busy[0], 1'b0);
        rstN = 1'b1;
        readyIn[0] = 1'b1;
        repeat (10) @(posedge CLK);
        accQ.delete();
        sendFrame(0, 16'hC3, 1'b0, 2'b11, d);
        expectFrame(0, 16'hC3, 1'b0, 2'b11, d, "postRst_c3");

        // Line held low across reset must not start a frame.
        @(posedge CLK); #1;
        lineIn[0] = 1'b0;
        rstN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        rstN = 1'b1;
        repeat (40) @(posedge CLK);
        #1;
        checkVal("lowRst.busy", busy[0], 1'b0);
        checkVal("lowRst.noDelivery", accQ.size(), 0);
        lineIn[0] = 1'b1;
        repeat (5) @(posedge CLK);
        sendFrame(0, 16'h96, 1'b0, 2'b11, d);
        expectFrame(0, 16'h96, 1'b0, 2'b11, d, "lowRst_96");

        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 6; n++) begin
                rdata = 16'($urandom);
                rpar  = 1'($urandom_range(0, 1));
                rstop = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
                sendFrame(k, rdata, rpar, rstop, d);
                expectFrame(k, rdata, rpar, rstop, d, $sformatf("rand%0d_%0d", k, n));
                repeat ($urandom_range(1, 20)) @(posedge CLK);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end
endmodule
